// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch lap core.
//   state_t      : FSM state encoding, also driven out on o_state
//   time_t       : displayed/live time, five packed BCD digits {m10, m1, s10, s1, t}
//   digit_mod()  : modulus of each digit position, index 0 = tenths
//   presc_width(): register width needed to count 0..presc-1
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StLap  = 2'd2,
    StStop = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    logic [3:0] t;
  } time_t;

  localparam int unsigned ModT   = 10;
  localparam int unsigned ModS1  = 10;
  localparam int unsigned ModS10 = 6;
  localparam int unsigned ModM1  = 10;
  localparam int unsigned ModM10 = 6;

  localparam time_t TimeZero = '{m10: 4'd0, m1: 4'd0, s10: 4'd0, s1: 4'd0, t: 4'd0};
  localparam time_t TimeOne  = '{m10: 4'd0, m1: 4'd0, s10: 4'd0, s1: 4'd0, t: 4'd1};
  localparam time_t TimeMax  = '{m10: 4'd5, m1: 4'd9, s10: 4'd5, s1: 4'd9, t: 4'd9};

  function automatic int unsigned digit_mod(int unsigned idx);
    case (idx)
      0:       return ModT;
      1:       return ModS1;
      2:       return ModS10;
      3:       return ModM1;
      default: return ModM10;
    endcase
  endfunction

  function automatic int unsigned presc_width(int unsigned presc);
    return (presc <= 2) ? 1 : $clog2(presc);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch chain, counting 0..MOD-1 up or down.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clr          : zero the digit (highest priority after reset)
//   i_load/i_value : load a preset digit, clamped to MOD-1
//   i_en           : advance by one this edge
//   i_down         : direction, 1 = decrement with borrow
//   o_digit        : current digit
//   o_carry        : carry/borrow to the next digit (terminal count AND i_en)
module bcd_digit_counter #(
  parameter int unsigned MOD = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_down,
  input  logic       i_load,
  input  logic [3:0] i_value,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  localparam logic [3:0] Max = 4'(MOD - 1);

  logic [3:0] digit_q, digit_d;
  logic       at_end;

  assign at_end = i_down ? (digit_q == 4'd0) : (digit_q == Max);

  always_comb begin
    digit_d = digit_q;
    if (i_clr) begin
      digit_d = 4'd0;
    end else if (i_load) begin
      digit_d = (i_value > Max) ? Max : i_value;
    end else if (i_en) begin
      if (at_end) begin
        digit_d = i_down ? Max : 4'd0;
      end else begin
        digit_d = i_down ? (digit_q - 4'd1) : (digit_q + 4'd1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign o_digit = digit_q;
  assign o_carry = at_end && i_en;

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: start/stop, lap freeze and clear, counting MM:SS.t in BCD from a single
// clock with one prescaler tick enable and a cascaded BCD digit chain.
// Optional build macro STOPWATCH_COUNTDOWN_EN adds preset load and down-counting.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start_stop   : pulse, toggle run/stop
//   i_lap          : pulse, capture/refresh lap value (IDLE: load preset when countdown built)
//   i_clear        : pulse, back to IDLE with time, lap and prescaler zeroed
//   i_down         : (countdown build) direction, sampled on entry to RUN
//   i_preset       : (countdown build) BCD preset {m10, m1, s10, s1, t}
//   o_digits       : lap value in LAP, live value otherwise
//   o_running      : RUN or LAP
//   o_lap_active   : LAP
//   o_tick         : one-cycle pulse after each prescaler rollover
//   o_overflow     : wrap/zero-reach pulse, or sticky saturation flag when WRAP = 0
//   o_state        : state_t encoding
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 10,
  parameter int unsigned WRAP    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_stop,
  input  logic        i_lap,
  input  logic        i_clear,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic        i_down,
  input  logic [19:0] i_preset,
`endif
  output logic [19:0] o_digits,
  output logic        o_running,
  output logic        o_lap_active,
  output logic        o_tick,
  output logic        o_overflow,
  output logic [1:0]  o_state
);

  localparam int unsigned Presc  = CLK_HZ / TICK_HZ;
  localparam int unsigned PrescW = presc_width(Presc);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(Presc - 1);

  state_t            state_q, state_d, state_base;
  logic [PrescW-1:0] presc_q, presc_d;
  time_t             lap_q, lap_d, live;
  logic              tick_q, ovf_pulse_q, ovf_pulse_d, ovf_sticky_q, ovf_sticky_d;
  logic              zero_all, capture, load_preset;
  logic              counting, tick_ev, sat, zero_hit, chain_en;
  logic              down_d;
  logic [19:0]       preset_digits;
  logic [4:0][3:0]   live_digits;
  logic [5:0]        en_chain;

`ifdef STOPWATCH_COUNTDOWN_EN
  localparam bit CountdownEn = 1'b1;
  logic down_q;

  // Direction is latched on every entry into RUN; a tick on that same edge already uses it.
  assign down_d        = ((state_base == StRun) && (state_q != StRun)) ? i_down : down_q;
  assign preset_digits = i_preset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      down_q <= 1'b0;
    end else begin
      down_q <= down_d;
    end
  end
`else
  localparam bit CountdownEn = 1'b0;
  assign down_d        = 1'b0;
  assign preset_digits = 20'd0;
`endif

  // Pulse-driven transitions, priority clear > start/stop > lap.
  always_comb begin
    state_base  = state_q;
    zero_all    = 1'b0;
    capture     = 1'b0;
    load_preset = 1'b0;
    if (i_clear) begin
      state_base = StIdle;
      zero_all   = 1'b1;
    end else if (i_start_stop) begin
      unique case (state_q)
        StIdle, StStop: state_base = StRun;
        StRun, StLap:   state_base = StStop;
        default:        state_base = state_q;
      endcase
    end else if (i_lap) begin
      unique case (state_q)
        StIdle: load_preset = CountdownEn;
        StRun: begin
          state_base = StLap;
          capture    = 1'b1;
        end
        StLap:  capture = 1'b1;
        StStop: begin
          state_base = StIdle;
          zero_all   = 1'b1;
        end
        default: state_base = state_q;
      endcase
    end
  end

  // The prescaler advances on every edge that lands in RUN/LAP, including the start edge,
  // so the first tick comes Presc edges after start and a stop/restart loses nothing.
  assign counting = (state_base == StRun) || (state_base == StLap);
  assign tick_ev  = counting && (presc_q == PrescMax);
  assign sat      = tick_ev && !down_d && (live == TimeMax) && (WRAP == 0);
  assign zero_hit = tick_ev && down_d && ((live == TimeOne) || (live == TimeZero));
  // Counting down from zero would borrow round to 59:59.9; hold instead.
  assign chain_en = tick_ev && !sat && !(down_d && (live == TimeZero));

  always_comb begin
    state_d = state_base;
    if (sat || zero_hit) begin
      state_d = StStop;
    end

    presc_d = presc_q;
    if (zero_all) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = tick_ev ? '0 : (presc_q + 1'b1);
    end

    lap_d = lap_q;
    if (zero_all) begin
      lap_d = TimeZero;
    end else if (capture) begin
      lap_d = live;
    end

    // en_chain[5] is the carry out of m10, i.e. 59:59.9 wrapping to zero.
    ovf_pulse_d  = en_chain[5] || zero_hit;
    ovf_sticky_d = i_clear ? 1'b0 : (ovf_sticky_q || sat);
  end

  assign en_chain[0] = chain_en;

  for (genvar i = 0; i < 5; i++) begin : g_digit
    bcd_digit_counter #(
      .MOD(digit_mod(i))
    ) u_digit (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (zero_all),
      .i_en    (en_chain[i]),
      .i_down  (down_d),
      .i_load  (load_preset),
      .i_value (preset_digits[4*i +: 4]),
      .o_digit (live_digits[i]),
      .o_carry (en_chain[i+1])
    );
  end

  assign live = time_t'(live_digits);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      lap_q        <= TimeZero;
      tick_q       <= 1'b0;
      ovf_pulse_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      lap_q        <= lap_d;
      tick_q       <= tick_ev;
      ovf_pulse_q  <= ovf_pulse_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Mux of registers only; no path from the pulse inputs.
  assign o_digits     = (state_q == StLap) ? lap_q : live;
  assign o_running    = (state_q == StRun) || (state_q == StLap);
  assign o_lap_active = (state_q == StLap);
  assign o_tick       = tick_q;
  assign o_overflow   = ovf_pulse_q || ovf_sticky_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core. DUT a: PRESC=10, WRAP=1 for the directed sequences.
// DUTs b (WRAP=1) and c (WRAP=0) use PRESC=2 so a full 59:59.9 run stays short.
// Each DUT is checked every cycle against a model that keeps time as an integer count of
// tenths; literal checks at hand-computed cycles pin the model itself.
module tb_stopwatch_lap_core;

  localparam int MIdle = 0, MRun = 1, MLap = 2, MStop = 3;
`ifdef STOPWATCH_COUNTDOWN_EN
  localparam bit CountdownEn = 1'b1;
`else
  localparam bit CountdownEn = 1'b0;
`endif

  typedef struct packed {
    int st;
    int live;
    int lapv;
    int presc;
    bit tick;
    bit pulse;
    bit sticky;
    bit down;
  } model_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_lap, a_clear, a_down;
  logic [19:0] a_preset;
  logic        bc_start, bc_lap, bc_clear;

  logic [19:0] a_digits, b_digits, c_digits;
  logic        a_running, b_running, c_running;
  logic        a_lapact, b_lapact, c_lapact;
  logic        a_tick, b_tick, c_tick;
  logic        a_ovf, b_ovf, c_ovf;
  logic [1:0]  a_state, b_state, c_state;

  int     checks = 0;
  int     failures = 0;
  bit     chk_en = 1'b0;
  int     cycle = 0;
  int     t0 = 0;
  model_t ma = '0, mb = '0, mc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  stopwatch_lap_core #(.CLK_HZ(100), .TICK_HZ(10), .WRAP(1)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_start_stop(a_start), .i_lap(a_lap), .i_clear(a_clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .i_down(a_down), .i_preset(a_preset),
`endif
    .o_digits(a_digits), .o_running(a_running), .o_lap_active(a_lapact), .o_tick(a_tick),
    .o_overflow(a_ovf), .o_state(a_state)
  );

  stopwatch_lap_core #(.CLK_HZ(20), .TICK_HZ(10), .WRAP(1)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_start_stop(bc_start), .i_lap(bc_lap), .i_clear(bc_clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .i_down(1'b0), .i_preset(20'd0),
`endif
    .o_digits(b_digits), .o_running(b_running), .o_lap_active(b_lapact), .o_tick(b_tick),
    .o_overflow(b_ovf), .o_state(b_state)
  );

  stopwatch_lap_core #(.CLK_HZ(20), .TICK_HZ(10), .WRAP(0)) u_dut_c (
    .i_clk(clk), .i_reset(rst), .i_start_stop(bc_start), .i_lap(bc_lap), .i_clear(bc_clear),
`ifdef STOPWATCH_COUNTDOWN_EN
    .i_down(1'b0), .i_preset(20'd0),
`endif
    .o_digits(c_digits), .o_running(c_running), .o_lap_active(c_lapact), .o_tick(c_tick),
    .o_overflow(c_ovf), .o_state(c_state)
  );

  // Tenths count (0..35999) to displayed BCD digits.
  function automatic logic [19:0] to_bcd(int x);
    int m, s;
    m = x / 600;
    s = (x % 600) / 10;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(x % 10)};
  endfunction

  function automatic int clampd(logic [3:0] d, int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  function automatic int preset_tenths(logic [19:0] p);
    return clampd(p[19:16], 5) * 6000 + clampd(p[15:12], 9) * 600 +
           clampd(p[11:8], 5) * 100 + clampd(p[7:4], 9) * 10 + clampd(p[3:0], 9);
  endfunction

  function automatic model_t mstep(model_t m, logic r, logic st, logic lp, logic clr, int pn,
                                   bit wrap, logic dn, logic [19:0] preset);
    model_t n;
    n = m;
    n.tick  = 1'b0;
    n.pulse = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (clr) begin
      n = '0;
      n.down = m.down;
      return n;
    end
    if (st) begin
      if (m.st == MIdle || m.st == MStop) begin
        n.st = MRun;
        n.down = CountdownEn && dn;
      end else begin
        n.st = MStop;
      end
    end else if (lp) begin
      case (m.st)
        MIdle: if (CountdownEn) n.live = preset_tenths(preset);
        MRun: begin
          n.st = MLap;
          n.lapv = m.live;
        end
        MLap: n.lapv = m.live;
        default: begin
          n.st = MIdle;
          n.live = 0;
          n.lapv = 0;
          n.presc = 0;
        end
      endcase
    end
    if (n.st == MRun || n.st == MLap) begin
      if (m.presc == pn - 1) begin
        n.presc = 0;
        n.tick = 1'b1;
        if (n.down) begin
          if (m.live <= 1) begin
            n.live = 0;
            n.st = MStop;
            n.pulse = 1'b1;
          end else begin
            n.live = m.live - 1;
          end
        end else if (m.live == 35999) begin
          if (wrap) begin
            n.live = 0;
            n.pulse = 1'b1;
          end else begin
            n.st = MStop;
            n.sticky = 1'b1;
          end
        end else begin
          n.live = m.live + 1;
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [25:0] expect_of(model_t m);
    return {2'(m.st), (m.st == MRun || m.st == MLap), (m.st == MLap), m.tick,
            (m.pulse || m.sticky), to_bcd((m.st == MLap) ? m.lapv : m.live)};
  endfunction

  always @(posedge clk) begin
    ma <= mstep(ma, rst, a_start, a_lap, a_clear, 10, 1'b1, a_down, a_preset);
    mb <= mstep(mb, rst, bc_start, bc_lap, bc_clear, 2, 1'b1, 1'b0, 20'd0);
    mc <= mstep(mc, rst, bc_start, bc_lap, bc_clear, 2, 1'b0, 1'b0, 20'd0);
  end

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle - t0, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      lit("model_a", {6'd0, a_state, a_running, a_lapact, a_tick, a_ovf, a_digits},
          {6'd0, expect_of(ma)});
      lit("model_b", {6'd0, b_state, b_running, b_lapact, b_tick, b_ovf, b_digits},
          {6'd0, expect_of(mb)});
      lit("model_c", {6'd0, c_state, c_running, c_lapact, c_tick, c_ovf, c_digits},
          {6'd0, expect_of(mc)});
    end
  end

  // Advance to relative cycle c (just after its rising edge).
  task automatic goto(int c);
    while (cycle < t0 + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic origin();
    @(posedge clk);
    #1;
    t0 = cycle;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_lap = 1'b0; a_clear = 1'b0; a_down = 1'b0; a_preset = 20'd0;
    bc_start = 1'b0; bc_lap = 1'b0; bc_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    lit("reset_a", {a_state, a_running, a_lapact, a_tick, a_ovf, a_digits}, 32'd0);
    lit("reset_c", {c_state, c_running, c_lapact, c_tick, c_ovf, c_digits}, 32'd0);
    rst = 1'b0;

    // Start from IDLE, first tick, one second.
    origin();
    a_start = 1'b1;
    goto(1); a_start = 1'b0;
    @(negedge clk); lit("running_after_start", {a_running, a_digits}, {1'b1, 20'h00000});
    goto(9); @(negedge clk); lit("no_tick_yet", {a_tick, a_digits}, 32'd0);
    goto(10); @(negedge clk); lit("first_tick", {a_tick, a_digits}, {1'b1, 20'h00001});
    goto(100); @(negedge clk); lit("one_second", {a_tick, a_digits}, {1'b1, 20'h00010});
    goto(101); a_clear = 1'b1;
    goto(102); a_clear = 1'b0;
    @(negedge clk); lit("clear_to_idle", {a_state, a_digits}, 32'd0);

    // Stop with prescaler mid-count, hold, resume.
    origin();
    a_start = 1'b1;
    goto(1); a_start = 1'b0;
    goto(35); a_start = 1'b1;
    @(negedge clk); lit("before_stop", a_digits, 32'h00003);
    goto(36); a_start = 1'b0;
    goto(85); @(negedge clk); lit("stop_held", {a_state, a_digits}, {2'd3, 20'h00003});
    goto(86); a_start = 1'b1;
    goto(87); a_start = 1'b0;
    goto(90); @(negedge clk); lit("resume_c4", a_digits, 32'h00003);
    goto(91); @(negedge clk); lit("resume_c5", {a_tick, a_digits}, {1'b1, 20'h00004});

    // Lap freeze while live keeps counting, then stop from LAP.
    goto(301); a_lap = 1'b1;
    goto(302); a_lap = 1'b0;
    @(negedge clk); lit("lap_capture", {a_lapact, a_digits}, {1'b1, 20'h00025});
    goto(351); @(negedge clk); lit("lap_frozen", {a_state, a_digits}, {2'd2, 20'h00025});
    goto(352); a_start = 1'b1;
    goto(353); a_start = 1'b0;
    @(negedge clk); lit("stop_from_lap", {a_state, a_digits}, {2'd3, 20'h00030});
    goto(354); a_clear = 1'b1;
    goto(355); a_clear = 1'b0;

    // Start+lap together, clear in LAP, reset mid-count.
    origin();
    a_start = 1'b1;
    goto(1); a_start = 1'b0;
    goto(15); a_start = 1'b1; a_lap = 1'b1;
    goto(16); a_start = 1'b0; a_lap = 1'b0;
    @(negedge clk); lit("start_beats_lap", {a_state, a_lapact}, {2'd3, 1'b0});
    goto(17); a_start = 1'b1;
    goto(18); a_start = 1'b0;
    goto(20); a_lap = 1'b1;
    goto(21); a_lap = 1'b0;
    @(negedge clk); lit("enter_lap", a_state, 32'd2);
    goto(24); a_clear = 1'b1;
    goto(25); a_clear = 1'b0;
    @(negedge clk);
    lit("clear_in_lap", {a_state, a_running, a_lapact, a_tick, a_ovf, a_digits}, 32'd0);
    goto(26); a_start = 1'b1;
    goto(27); a_start = 1'b0;
    goto(35); @(negedge clk); lit("presc_zeroed_c9", {a_tick, a_digits}, 32'd0);
    goto(36); @(negedge clk); lit("presc_zeroed_c10", {a_tick, a_digits}, {1'b1, 20'h00001});
    goto(40); rst = 1'b1;
    goto(41); rst = 1'b0;
    @(negedge clk);
    lit("reset_mid_count", {a_state, a_running, a_lapact, a_tick, a_ovf, a_digits}, 32'd0);
    goto(42); a_lap = 1'b1;
    goto(43); a_lap = 1'b0;
    @(negedge clk); lit("lap_in_idle", a_state, 32'd0);

`ifdef STOPWATCH_COUNTDOWN_EN
    // Preset clamp, then count down to zero.
    goto(45); a_preset = 20'hFFFFF; a_lap = 1'b1;
    goto(46); a_lap = 1'b0;
    @(negedge clk); lit("preset_clamp", {a_state, a_digits}, {2'd0, 20'h59599});
    goto(47); a_clear = 1'b1;
    goto(48); a_clear = 1'b0;
    goto(49); a_preset = 20'h00003; a_lap = 1'b1;
    goto(50); a_lap = 1'b0;
    @(negedge clk); lit("preset_load", {a_state, a_digits}, {2'd0, 20'h00003});
    origin();
    a_down = 1'b1; a_start = 1'b1;
    goto(1); a_start = 1'b0;
    goto(10); @(negedge clk); lit("down_c10", a_digits, 32'h00002);
    goto(20); @(negedge clk); lit("down_c20", a_digits, 32'h00001);
    goto(30); @(negedge clk);
    lit("down_zero", {a_state, a_ovf, a_tick, a_digits}, {2'd3, 1'b1, 1'b1, 20'h00000});
    goto(31); @(negedge clk); lit("down_ovf_pulse", {a_state, a_ovf}, {2'd3, 1'b0});
    a_down = 1'b0;
`endif

    // Full-range run: wrap (b) and saturate (c).
    origin();
    bc_start = 1'b1;
    goto(1); bc_start = 1'b0;
    goto(71998); @(negedge clk);
    lit("b_max", b_digits, 32'h59599);
    lit("c_max", c_digits, 32'h59599);
    goto(72000); @(negedge clk);
    lit("b_wrap", {b_state, b_tick, b_ovf, b_digits}, {2'd1, 1'b1, 1'b1, 20'h00000});
    lit("c_saturate", {c_state, c_ovf, c_digits}, {2'd3, 1'b1, 20'h59599});
    goto(72001); @(negedge clk); lit("b_ovf_pulse_end", {b_tick, b_ovf}, 32'd0);
    goto(72100); @(negedge clk); lit("c_ovf_sticky", {c_state, c_ovf}, {2'd3, 1'b1});
    bc_start = 1'b1;
    goto(72101); bc_start = 1'b0;
    @(negedge clk); lit("c_restart", {c_state, c_digits}, {2'd1, 20'h59599});
    goto(72102); @(negedge clk); lit("c_resaturate", {c_state, c_ovf}, {2'd3, 1'b1});
    goto(72110); bc_clear = 1'b1;
    goto(72111); bc_clear = 1'b0;
    @(negedge clk); lit("c_clear", {c_state, c_ovf, c_digits}, 32'd0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
